// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ==========================================================================
// Module : hazard_scoreboard
// Desc   : Decode-stage register scoreboard with issue/stall decision.
// Rev    : 1.0  initial release
// ==========================================================================
module hazard_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [IDX_W-1:0] id_rs1_idx_i,
    input  logic [IDX_W-1:0] id_rs2_idx_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [IDX_W-1:0] id_rd_idx_i,
    input  logic             id_rd_wen_i,
    input  logic [1:0]       id_lat_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic [IDX_W-1:0] wb_rd_idx_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [REG_NUM-1:0]      pend_q, pend_d;
    logic [REG_NUM-1:0][1:0] rdy_q, rdy_d;
    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic                    haz_rs1, haz_rs2, hazard;
    logic [1:0]              new_rdy;

    // A same-cycle final writeback of the source supplies it on the last bypass.
    always_comb begin
        haz_rs1 = id_rs1_used_i && (id_rs1_idx_i != '0) && pend_q[id_rs1_idx_i]
                  && (rdy_q[id_rs1_idx_i] != 2'd0)
                  && !(wb_valid_i && (wb_rd_idx_i == id_rs1_idx_i));
        haz_rs2 = id_rs2_used_i && (id_rs2_idx_i != '0) && pend_q[id_rs2_idx_i]
                  && (rdy_q[id_rs2_idx_i] != 2'd0)
                  && !(wb_valid_i && (wb_rd_idx_i == id_rs2_idx_i));
        hazard  = haz_rs1 || haz_rs2;
    end

    assign issue_o     = id_valid_i && !hazard && !flush_i;
    assign stall_o     = id_valid_i &&  hazard && !flush_i;
    assign busy_o      = |pend_q[REG_NUM-1:1];
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        case (id_lat_i)
            2'd0:    new_rdy = 2'd0;
            2'd1:    new_rdy = 2'd2;
            default: new_rdy = 2'd3;
        endcase
    end

    // Issue is applied after writeback so a WAW reload owns the entry.
    always_comb begin
        pend_d = pend_q;
        rdy_d  = rdy_q;
        for (int i = 1; i < REG_NUM; i++) begin
            if (pend_q[i] && ((rdy_q[i] == 2'd1) || (rdy_q[i] == 2'd2)))
                rdy_d[i] = rdy_q[i] - 2'd1;
            if (wb_valid_i && (wb_rd_idx_i == IDX_W'(i)))
                pend_d[i] = 1'b0;
            if (issue_o && id_rd_wen_i && (id_rd_idx_i == IDX_W'(i))) begin
                pend_d[i] = 1'b1;
                rdy_d[i]  = new_rdy;
            end
        end
        pend_d[0] = 1'b0;
        rdy_d[0]  = 2'd0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = stall_o ? ST_STALL : ST_RUN;
            ST_STALL: begin
                if (stall_o)
                    state_d = ST_STALL;
                else if (issue_o || flush_i || !id_valid_i)
                    state_d = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            rdy_q       <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            pend_q      <= pend_d;
            rdy_q       <= rdy_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ==========================================================================
// Module : tb_hazard_scoreboard
// Desc   : Scoreboard bench for hazard_scoreboard against a cycle-time model.
// Rev    : 1.0  initial release
// ==========================================================================
module tb_hazard_scoreboard;

    localparam int INF = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid_i;
    logic [4:0] id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i, wb_rd_idx_i;
    logic       id_rs1_used_i, id_rs2_used_i, id_rd_wen_i;
    logic [1:0] id_lat_i;
    logic       flush_i, wb_valid_i;
    logic       issue_o, stall_o, busy_o;
    logic [15:0] stall_cnt_o;
    logic       sat_issue, sat_stall, sat_busy;
    logic [1:0] sat_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_idx_i(id_rd_idx_i), .id_rd_wen_i(id_rd_wen_i), .id_lat_i(id_lat_i),
        .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_idx_i(wb_rd_idx_i),
        .issue_o(issue_o), .stall_o(stall_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
    );

    hazard_scoreboard #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_idx_i(id_rd_idx_i), .id_rd_wen_i(id_rd_wen_i), .id_lat_i(id_lat_i),
        .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_idx_i(wb_rd_idx_i),
        .issue_o(sat_issue), .stall_o(sat_stall), .busy_o(sat_busy), .stall_cnt_o(sat_cnt)
    );

    typedef struct {
        bit issue;
        bit stall;
        bit busy;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: each register records the cycle at which its value becomes forwardable.
    bit m_pend[32];
    int m_avail[32];
    int cyc    = 0;
    int m_cnt  = 0;
    int m_cnt2 = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_pend[r]  = 1'b0;
            m_avail[r] = 0;
        end
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    function automatic bit src_haz(bit used, int idx);
        if (!used || idx == 0 || !m_pend[idx]) return 1'b0;
        if (cyc >= m_avail[idx]) return 1'b0;
        if (wb_valid_i && int'(wb_rd_idx_i) == idx) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        exp_t e;
        bit   h, iss, stl, bsy;
        if (!rst_n) model_reset();
        h   = src_haz(id_rs1_used_i, int'(id_rs1_idx_i)) || src_haz(id_rs2_used_i, int'(id_rs2_idx_i));
        iss = id_valid_i && !h && !flush_i;
        stl = id_valid_i &&  h && !flush_i;
        bsy = 1'b0;
        for (int r = 1; r < 32; r++) bsy = bsy | m_pend[r];
        e.issue = iss;
        e.stall = stl;
        e.busy  = bsy;
        e.cnt   = m_cnt;
        e.cnt2  = m_cnt2;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (wb_valid_i && wb_rd_idx_i != 5'd0) m_pend[int'(wb_rd_idx_i)] = 1'b0;
            if (iss && id_rd_wen_i && id_rd_idx_i != 5'd0) begin
                m_pend[int'(id_rd_idx_i)]  = 1'b1;
                m_avail[int'(id_rd_idx_i)] = (id_lat_i == 2'd0) ? cyc + 1 :
                                             (id_lat_i == 2'd1) ? cyc + 3 : INF;
            end
            if (stl) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        id_valid_i = 0; id_rs1_idx_i = 0; id_rs2_idx_i = 0;
        id_rs1_used_i = 0; id_rs2_used_i = 0; id_rd_idx_i = 0;
        id_rd_wen_i = 0; id_lat_i = 0; flush_i = 0;
        wb_valid_i = 0; wb_rd_idx_i = 0;
    endtask

    task automatic set_instr(int rs1, bit u1, int rs2, bit u2, int rd, bit wen, int lat);
        id_valid_i = 1;
        id_rs1_idx_i = 5'(rs1); id_rs1_used_i = u1;
        id_rs2_idx_i = 5'(rs2); id_rs2_used_i = u2;
        id_rd_idx_i = 5'(rd); id_rd_wen_i = wen; id_lat_i = 2'(lat);
        flush_i = 0; wb_valid_i = 0; wb_rd_idx_i = 0;
    endtask

    task automatic set_wb(int idx);
        wb_valid_i  = 1;
        wb_rd_idx_i = 5'(idx);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue",     int'(issue_o),     int'(e.issue));
                check("stall",     int'(stall_o),     int'(e.stall));
                check("busy",      int'(busy_o),      int'(e.busy));
                check("stall_cnt", int'(stall_cnt_o), e.cnt);
                check("sat_cnt",   int'(sat_cnt),     e.cnt2);
                check("sat_stall", int'(sat_stall),   int'(e.stall));
            end
        end
    end

    initial begin
        rst_n = 0;
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        // Reset with a valid decode instruction present.
        set_instr(5, 1, 0, 0, 5, 1, 0);
        repeat (3) tick();
        rst_n = 1;
        set_idle(); tick();
        // ALU chain.
        set_instr(1, 1, 2, 1, 5, 1, 0); tick();
        set_instr(5, 1, 0, 0, 0, 0, 0); tick();
        set_idle(); set_wb(5); tick();
        // Load-use.
        set_instr(3, 1, 0, 0, 6, 1, 1); tick();
        set_instr(0, 0, 6, 1, 0, 0, 0); repeat (3) tick();
        set_idle(); set_wb(6); tick();
        // Long op resolved by a same-cycle writeback.
        set_instr(1, 1, 2, 1, 7, 1, 2); tick();
        set_instr(7, 1, 7, 1, 0, 0, 0); repeat (6) tick();
        set_wb(7); tick();
        set_idle(); tick();
        // x0 destination and x0 source.
        set_instr(1, 1, 0, 0, 0, 1, 2); tick();
        set_instr(0, 1, 0, 1, 0, 0, 0); tick();
        // Flush during a stall.
        set_instr(0, 0, 0, 0, 9, 1, 1); tick();
        set_instr(9, 1, 0, 0, 0, 0, 0); tick();
        flush_i = 1; tick();
        set_idle(); set_wb(9); tick();
        // WAW with a same-cycle writeback of the same register.
        set_instr(0, 0, 0, 0, 8, 1, 2); tick();
        set_instr(0, 0, 0, 0, 8, 1, 0); set_wb(8); tick();
        set_instr(8, 1, 8, 1, 0, 0, 0); tick();
        // Long stall to saturate the narrow counter.
        set_instr(0, 0, 0, 0, 10, 1, 3); tick();
        set_instr(10, 1, 0, 0, 0, 0, 0); repeat (6) tick();
        // Asynchronous reset in mid-operation.
        rst_n = 0; tick();
        rst_n = 1; tick();
        set_idle(); tick();
        // Randomized traffic on a small register window.
        for (int n = 0; n < 3000; n++) begin
            id_valid_i    = ($urandom_range(0, 3) != 0);
            id_rs1_idx_i  = 5'($urandom_range(0, 11));
            id_rs2_idx_i  = 5'($urandom_range(0, 11));
            id_rs1_used_i = 1'($urandom_range(0, 1));
            id_rs2_used_i = 1'($urandom_range(0, 1));
            id_rd_idx_i   = 5'($urandom_range(0, 11));
            id_rd_wen_i   = ($urandom_range(0, 3) != 0);
            id_lat_i      = 2'($urandom_range(0, 3));
            flush_i       = ($urandom_range(0, 9) == 0);
            wb_valid_i    = ($urandom_range(0, 2) == 0);
            wb_rd_idx_i   = 5'($urandom_range(0, 11));
            rst_n         = (n != 1500);
            tick();
        end
        rst_n = 1;
        set_idle(); tick();
        check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register scoreboard and issue controller for the operand-forwarding path. Tracks every in-flight write to the 32 architectural integer registers, and tracks how many cycles remain before each result reaches a bypass point. It decides each cycle whether the instruction in decode may issue or must stall. It sits in the decode stage and ensures forwarding only selects values that already exist on the pipe or writeback bypass.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired zero.
- IDX_W, 5, register index width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- id_valid_i  input  1  decode holds a valid instruction.
- id_rs1_idx_i, id_rs2_idx_i  input  IDX_W  source indices.
- id_rs1_used_i, id_rs2_used_i  input  1  source is read as a register operand.
- id_rd_idx_i  input  IDX_W  destination index.
- id_rd_wen_i  input  1  instruction writes rd.
- id_lat_i  input  2  producer class: 0 = ALU, 1 = load, 2 = long (mul/div), 3 = reserved (treated as 2).
- flush_i  input  1  kill the decode instruction this cycle.
- wb_valid_i  input  1  final writeback of a register this cycle.
- wb_rd_idx_i  input  IDX_W  writeback index.
- issue_o  output  1  decode instruction issues this cycle.
- stall_o  output  1  hold fetch/decode this cycle.
- busy_o  output  1  at least one register pending.
- stall_cnt_o  output  CNT_W  saturating count of stalled cycles.

## Operation
Per-register state for each index 1..31:
- pend[i]: a write is outstanding.
- rdy[i]: 2-bit distance to forwardability.
  - 0: value is forwardable now.
  - 1 or 2: counts down by 1 each cycle.
  - 3: sticky; forwardable only at writeback.
- Index 0 is never pending, is never a hazard, and ignores all updates.

Hazard for source s (rs1 or rs2):
- Condition: used_s & idx_s != 0 & pend[idx_s] & rdy[idx_s] != 0 & ~(wb_valid_i & wb_rd_idx_i == idx_s).
- A same-cycle final writeback resolves the hazard, because the final bypass supplies the value.
- hazard = hazard_rs1 | hazard_rs2.

Outputs:
- issue_o = id_valid_i & ~hazard & ~flush_i.
- stall_o = id_valid_i & hazard & ~flush_i.

On issue with id_rd_wen_i & id_rd_idx_i != 0, load the destination entry:
- pend = 1.
- rdy = 0 for ALU, 2 for load, 3 for long.

On wb_valid_i with wb_rd_idx_i != 0: clear pend for that index.

Same-cycle update to the same index: issue wins, and the entry is reloaded as a new producer (WAW). There is no stall on WAW; the younger producer owns the entry.

rdy decrement applies to every pending entry with rdy of 1 or 2 that is not being reloaded this cycle.

flush_i:
- Suppresses issue_o and stall_o for that cycle.
- Does not touch the scoreboard; older instructions still complete.

FSM, for the performance counter and debug:
- RUN to STALL when stall_o = 1.
- STALL to RUN when issue_o, flush_i, or ~id_valid_i.
- STALL to STALL while stall_o = 1.
- stall_cnt_o increments in every cycle where stall_o = 1, and saturates at all-ones.

busy_o = OR of pend[31:1] (registered state).

## Timing
- Reset (async, rst_n = 0):
  - All pend = 0, all rdy = 0, FSM = RUN, stall_cnt_o = 0.
  - Combinational outputs then reflect inputs: issue_o = id_valid_i & ~flush_i, stall_o = 0, busy_o = 0.
- Reset mid-operation discards all outstanding state immediately, with no drain.
- issue_o and stall_o are combinational from registered state plus current inputs, with zero-cycle decision latency.
- State updates at the clock edge after issue or writeback.
- Dependent-instruction stalls, assuming no intermediate writeback:
  - ALU producer: 0 stall cycles; forwardable from the pipe the next cycle.
  - Load producer: stalls 2 cycles, then issues on the 3rd cycle after the load issued.
  - Long producer: stalls until the cycle wb_valid_i presents its index, and issues in that same cycle.
- Both sources hitting the same pending register: a single hazard, same latency.

## Test plan
- Reset then idle: rst_n low with id_valid_i = 1 -> stall_o = 0, busy_o = 0, stall_cnt_o = 0; after release, an ALU op with rd = 5 -> busy_o = 1 next cycle.
- ALU chain: issue add x5; next cycle use rs1 = x5 -> issue_o = 1, stall_o = 0, stall_cnt_o unchanged.
- Load-use: issue load x6 (lat 1), then an instruction with rs2 = x6 -> stall_o = 1 for exactly 2 cycles, issue on the 3rd; stall_cnt_o = 2.
- Long op: issue div x7 (lat 2), consumer with rs1 = x7 -> stalled until wb_valid_i = 1 with wb_rd_idx_i = 7 at cycle 10 -> issue_o = 1 in cycle 10, pend[7] cleared, busy_o = 0 next cycle.
- x0 and flush:
  - rd = 0 issue -> busy_o stays 0; source x0 never stalls.
  - flush_i during a stall -> issue_o = 0, stall_o = 0, FSM returns to RUN.
- WAW plus same-cycle wb: issue ALU x8 in the same cycle that wb_valid_i = 1 clears x8 -> pend[8] = 1, rdy = 0; stall_cnt_o saturation checked with CNT_W = 2 -> holds at 3.
